rpn_calc_ctrl: RTL and testbench
================================

// Module: rpn_calc_ctrl
// PURPOSE
//  Parametrised successor to the lab RPN calculator controller. Sequences operand A, operand B
//  and opcode entry from switch data using Enter/Undo, computes a registered result with flags,
//  and drives a display value and status code for the 7-segment driver downstream.
//  Adds the following over the previous generation:
//   - generic datapath width
//   - built-in edge detection on Enter/Undo
//   - multi-step undo
//   - optional result chaining
// PARAMETERS
//  WIDTH   16   datapath width of operands, result and display value (>= 4)
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-low reset
//  DataIn        in   WIDTH  switch data; opcode taken from DataIn[1:0] in WAIT_OP
//  Enter         in   1      level input (debounced upstream); action on rising edge
//  Undo          in   1      level input (debounced upstream); action on rising edge
//  Result        out  WIDTH  registered ALU result
//  Flags         out  5      {N,Z,C,V,P}, valid only in SHOW_RES
//  Status        out  3      state code: 0=WAIT_A 1=WAIT_B 2=WAIT_OP 3=SHOW_RES
//  DisplayValue  out  WIDTH  DataIn in WAIT_A/WAIT_B/WAIT_OP, Result in SHOW_RES
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state WAIT_A; A, B, Op, Result, Flags, edge regs all 0.
//    Applies mid-operation with no residue.
//  - Edge detect: registered previous Enter/Undo.
//    An event = input 1 this cycle and 0 in the previous cycle.
//    A held input produces exactly one event. Edge regs reset to 0.
//  - Latency: state/register update at the clk edge that samples the event;
//    visible on outputs the following cycle.
//  - Enter transitions:
//      WAIT_A   -> WAIT_B    A <= DataIn
//      WAIT_B   -> WAIT_OP   B <= DataIn
//      WAIT_OP  -> SHOW_RES  Op <= DataIn[1:0]; Result, Flags <= ALU(A, B, DataIn[1:0])
//      SHOW_RES: see CONFIGURATION
//  - Undo transitions (one step back, registers kept, overwritten on next Enter):
//      WAIT_B   -> WAIT_A
//      WAIT_OP  -> WAIT_B
//      SHOW_RES -> WAIT_OP   Flags cleared to 0
//      WAIT_A: no-op
//  - Simultaneous Enter and Undo events in the same cycle: Undo wins, Enter is discarded.
//  - Opcodes: 00 ADD, 01 SUB (A-B), 10 OR, 11 AND. Arithmetic is modulo 2^WIDTH.
//  - Flags:
//      N = Result[WIDTH-1]
//      Z = (Result == 0)
//      C = carry out of A+B (ADD), or of A+~B+1 (SUB; 1 when A >= B unsigned); 0 for logic ops
//      V = signed two's-complement overflow (ADD/SUB only); 0 for logic ops
//      P = 1 when Result has an even number of ones
//  - Flags read 0 whenever state != SHOW_RES. Result holds its last value outside SHOW_RES.
// CONFIGURATION
//  RPN_CHAIN_EN defined: Enter in SHOW_RES -> WAIT_B, A <= Result, Flags cleared
//    (chained calculation).
//  RPN_CHAIN_EN undefined: Enter in SHOW_RES -> WAIT_A; A, B, Op, Result, Flags cleared to 0.
// STRUCTURE
//  - Package rpn_pkg: state_t enum (WAIT_A=3'd0..SHOW_RES=3'd3), op_t enum (OP_ADD..OP_AND),
//    flag bit-index localparams FLAG_N..FLAG_P.
//  - Sub-module rpn_alu #(WIDTH): combinational; (A, B, op) -> result plus {N,Z,C,V,P}.
//  - Top holds edge detection, FSM and registers.
// TESTING (WIDTH=16)
//  1. A=0x000A Enter, B=0x0007 Enter, DataIn=0x0 Enter
//     -> Status=3, Result=0x0011, Flags N0 Z0 C0 V0 P1, DisplayValue=0x0011.
//  2. A=0x000A, B=0x0007, Undo (Status=0), B=0x0002, op 01
//     -> Result=0x0008, C=1, P=0. Then Undo -> Status=2, Flags=0.
//  3. A=0x0003, B=0x0007, SUB -> Result=0xFFFC, N=1, C=0, P=1.
//     A=0x7FFF, B=0x0001, ADD -> 0x8000, N=1, V=1, C=0.
//  4. A=0xF0F0, B=0x0F0F, AND -> Result=0x0000, Z=1, P=1.
//     Enter held 10 cycles -> single advance only.
//     Simultaneous Enter+Undo edges in WAIT_B -> Status=0.
//  5. From result 0x0011, Enter: with RPN_CHAIN_EN -> Status=1, then B=0x0003 ADD -> 0x0014.
//     Without RPN_CHAIN_EN -> Status=0, Result=0.
//  6. reset=0 for one cycle while in WAIT_OP -> next cycle Status=0, Flags=0, Result=0.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator controller: FSM states, ALU opcodes and
// bit positions of the {N,Z,C,V,P} flag vector.
package rpn_pkg;

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    SHOW_RES = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } op_t;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_P = 0;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN calculator: ADD, SUB (a-b), OR, AND with
// N/Z/C/V/P flags. Arithmetic wraps modulo 2^WIDTH.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic           carry;
  logic           overflow;

  assign add_ext = {1'b0, a} + {1'b0, b};
  // Subtraction as a + ~b + 1 so the carry is the "no borrow" bit (a >= b).
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = add_ext[WIDTH-1:0];
        carry    = add_ext[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result   = sub_ext[WIDTH-1:0];
        carry    = sub_ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  result = a | b;
      OP_AND: result = a & b;
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = overflow;
    flags[FLAG_P] = ~(^result);
  end

endmodule

// File: rtl/rpn_calc_ctrl.sv
// RPN calculator controller: Enter/Undo edge detection, entry FSM, result/flag
// registers and display mux. Define RPN_CHAIN_EN to chain results into operand A.
module rpn_calc_ctrl
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Enter,
  input  logic             Undo,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       Flags,
  output logic [2:0]       Status,
  output logic [WIDTH-1:0] DisplayValue
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  op_t              op_reg, op_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [4:0]       flags_reg, flags_next;
  logic             enter_prev_reg;
  logic             undo_prev_reg;

  logic             enter_event;
  logic             undo_event;
  logic [WIDTH-1:0] alu_result;
  logic [4:0]       alu_flags;

  assign enter_event = Enter & ~enter_prev_reg;
  assign undo_event  = Undo & ~undo_prev_reg;

  // ALU sees the opcode being latched this cycle so the result is ready at the same edge.
  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .op     (op_next),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= WAIT_A;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= OP_ADD;
      result_reg     <= '0;
      flags_reg      <= '0;
      enter_prev_reg <= 1'b0;
      undo_prev_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      op_reg         <= op_next;
      result_reg     <= result_next;
      flags_reg      <= flags_next;
      enter_prev_reg <= Enter;
      undo_prev_reg  <= Undo;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    flags_next  = flags_reg;

    // Undo has priority; a coincident Enter edge is dropped.
    if (undo_event) begin
      case (state_reg)
        WAIT_B:   state_next = WAIT_A;
        WAIT_OP:  state_next = WAIT_B;
        SHOW_RES: begin
          state_next = WAIT_OP;
          flags_next = '0;
        end
        default:  state_next = state_reg;
      endcase
    end else if (enter_event) begin
      case (state_reg)
        WAIT_A: begin
          state_next = WAIT_B;
          a_next     = DataIn;
        end
        WAIT_B: begin
          state_next = WAIT_OP;
          b_next     = DataIn;
        end
        WAIT_OP: begin
          state_next  = SHOW_RES;
          op_next     = op_t'(DataIn[1:0]);
          result_next = alu_result;
          flags_next  = alu_flags;
        end
        SHOW_RES: begin
`ifdef RPN_CHAIN_EN
          state_next = WAIT_B;
          a_next     = result_reg;
          flags_next = '0;
`else
          state_next  = WAIT_A;
          a_next      = '0;
          b_next      = '0;
          op_next     = OP_ADD;
          result_next = '0;
          flags_next  = '0;
`endif
        end
        default: state_next = WAIT_A;
      endcase
    end
  end

  assign Result       = result_reg;
  assign Status       = state_reg;
  assign Flags        = (state_reg == SHOW_RES) ? flags_reg : 5'd0;
  assign DisplayValue = (state_reg == SHOW_RES) ? result_reg : DataIn;

endmodule

// File: tb/tb_rpn_calc_ctrl.sv
// Self-checking bench for rpn_calc_ctrl (WIDTH=16): directed scenarios plus
// randomized Enter/Undo/reset traffic against an arithmetic reference model.
module tb_rpn_calc_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] DataIn;
  logic         Enter;
  logic         Undo;
  logic [W-1:0] Result;
  logic [4:0]   Flags;
  logic [2:0]   Status;
  logic [W-1:0] DisplayValue;

  int n_checks;
  int n_errors;

  // reference model state
  int         m_state;
  int         m_a, m_b, m_op;
  logic [15:0] m_res;
  logic [4:0]  m_flags;
  bit         m_pe, m_pu;

  rpn_calc_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .DataIn       (DataIn),
    .Enter        (Enter),
    .Undo         (Undo),
    .Result       (Result),
    .Flags        (Flags),
    .Status       (Status),
    .DisplayValue (DisplayValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Returns {N,Z,C,V,P, result[15:0]} from plain integer arithmetic.
  function automatic logic [20:0] alu_model(input int a, input int b, input int op);
    int          s, sv;
    logic [15:0] res;
    bit          c, v;
    c = 0; v = 0;
    case (op)
      0: begin
        s = a + b; res = s[15:0]; c = (s > 65535);
        sv = to_signed(a) + to_signed(b); v = (sv > 32767) || (sv < -32768);
      end
      1: begin
        s = a - b; res = s[15:0]; c = (a >= b);
        sv = to_signed(a) - to_signed(b); v = (sv > 32767) || (sv < -32768);
      end
      2: begin s = a | b; res = s[15:0]; end
      default: begin s = a & b; res = s[15:0]; end
    endcase
    return {res[15], (res == 16'd0), c, v, ($countones(res) % 2 == 0), res};
  endfunction

  task automatic model_step(input bit en, input bit un, input bit rst, input int d);
    bit          ev_e, ev_u;
    logic [20:0] r;
    if (!rst) begin
      m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
      m_pe = 0; m_pu = 0;
      return;
    end
    ev_e = en && !m_pe;
    ev_u = un && !m_pu;
    m_pe = en;
    m_pu = un;
    if (ev_u) begin
      if (m_state == 3) m_flags = 0;
      if (m_state > 0) m_state = m_state - 1;
    end else if (ev_e) begin
      if (m_state == 0) begin
        m_a = d; m_state = 1;
      end else if (m_state == 1) begin
        m_b = d; m_state = 2;
      end else if (m_state == 2) begin
        m_op = d % 4;
        r = alu_model(m_a, m_b, m_op);
        m_res = r[15:0]; m_flags = r[20:16]; m_state = 3;
      end else begin
`ifdef RPN_CHAIN_EN
        m_a = m_res; m_flags = 0; m_state = 1;
`else
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_state = 0;
`endif
      end
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, compare 1ns later.
  task automatic cycle(input bit en, input bit un, input bit rst, input int d);
    @(negedge clk);
    Enter  = en;
    Undo   = un;
    reset  = rst;
    DataIn = d[15:0];
    @(posedge clk);
    model_step(en, un, rst, d);
    #1;
    check("status", {29'd0, Status}, m_state);
    check("result", {16'd0, Result}, {16'd0, m_res});
    check("flags", {27'd0, Flags}, (m_state == 3) ? {27'd0, m_flags} : 32'd0);
    check("display", {16'd0, DisplayValue}, (m_state == 3) ? {16'd0, m_res} : d);
  endtask

  task automatic press_enter(input int d);
    cycle(1, 0, 1, d);
    cycle(0, 0, 1, d);
    $display("enter  data=0x%04h status=%0d result=0x%04h flags=%05b", d[15:0], Status, Result, Flags);
  endtask

  task automatic press_undo();
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    $display("undo   status=%0d result=0x%04h flags=%05b", Status, Result, Flags);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
  endtask

  task automatic calc(input int a, input int b, input int op);
    press_enter(a);
    press_enter(b);
    press_enter(op);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_pe = 0; m_pu = 0;
    Enter = 0; Undo = 0; reset = 0; DataIn = '0;

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 16'h1234);
    check("reset_status", {29'd0, Status}, 0);
    check("reset_result", {16'd0, Result}, 0);
    check("reset_flags", {27'd0, Flags}, 0);

    // 1: ADD
    calc(16'h000A, 16'h0007, 0);
    check("t1_status", {29'd0, Status}, 3);
    check("t1_result", {16'd0, Result}, 16'h0011);
    check("t1_flags", {27'd0, Flags}, 5'b00001);
    check("t1_display", {16'd0, DisplayValue}, 16'h0011);

    // 2: undo back to WAIT_A, re-enter, SUB, undo from SHOW_RES
    do_reset();
    press_enter(16'h000A);
    press_undo();
    check("t2_undo_status", {29'd0, Status}, 0);
    calc(16'h000A, 16'h0002, 1);
    check("t2_result", {16'd0, Result}, 16'h0008);
    check("t2_flags", {27'd0, Flags}, 5'b00100);
    press_undo();
    check("t2_undo2_status", {29'd0, Status}, 2);
    check("t2_undo2_flags", {27'd0, Flags}, 0);

    // 3: negative SUB, signed overflow ADD
    do_reset();
    calc(16'h0003, 16'h0007, 1);
    check("t3_sub_result", {16'd0, Result}, 16'hFFFC);
    check("t3_sub_flags", {27'd0, Flags}, 5'b10001);
    do_reset();
    calc(16'h7FFF, 16'h0001, 0);
    check("t3_add_result", {16'd0, Result}, 16'h8000);
    check("t3_add_flags", {27'd0, Flags}, 5'b10010);

    // 4: AND zero, held Enter, simultaneous edges
    do_reset();
    calc(16'hF0F0, 16'h0F0F, 3);
    check("t4_and_result", {16'd0, Result}, 16'h0000);
    check("t4_and_flags", {27'd0, Flags}, 5'b01001);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 16'h0055);
    cycle(0, 0, 1, 16'h0055);
    check("t4_hold_status", {29'd0, Status}, 1);
    cycle(1, 1, 1, 16'h0066);
    cycle(0, 0, 1, 16'h0066);
    check("t4_simul_status", {29'd0, Status}, 0);

    // 5: Enter from SHOW_RES
    do_reset();
    calc(16'h000A, 16'h0007, 0);
    press_enter(16'h0000);
`ifdef RPN_CHAIN_EN
    check("t5_chain_status", {29'd0, Status}, 1);
    press_enter(16'h0003);
    press_enter(0);
    check("t5_chain_result", {16'd0, Result}, 16'h0014);
`else
    check("t5_clear_status", {29'd0, Status}, 0);
    check("t5_clear_result", {16'd0, Result}, 0);
`endif

    // 6: reset while in WAIT_OP
    do_reset();
    calc(16'h0001, 16'h0001, 0);
    press_undo();
    check("t6_pre_status", {29'd0, Status}, 2);
    cycle(0, 0, 0, 16'h00FF);
    check("t6_status", {29'd0, Status}, 0);
    check("t6_flags", {27'd0, Flags}, 0);
    check("t6_result", {16'd0, Result}, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
      cycle(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 199) != 0), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
